// File: rtl/config_pkg.sv
// Shared DDR interface types for the arbiter and its clients.
package config_pkg;
  typedef logic [31:0] ddr_address_t;
  typedef logic [31:0] ddr_data_t;
endpackage

// File: rtl/ddr_port_arbiter.sv
// Two-port round-robin arbiter in front of a single DDR command port, with an
// in-order tag FIFO that routes read returns back to the issuing port.
module ddr_port_arbiter
  import config_pkg::*;
#(
  parameter int MaxOutstanding = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  ddr_address_t rq0_address_i,
  input  logic         rq0_r_en_i,
  input  logic         rq0_w_en_i,
  input  ddr_data_t    rq0_w_data_i,
  output logic         rq0_waitrequest_n_o,
  output ddr_data_t    rq0_r_data_o,
  output logic         rq0_r_valid_o,

  input  ddr_address_t rq1_address_i,
  input  logic         rq1_r_en_i,
  input  logic         rq1_w_en_i,
  input  ddr_data_t    rq1_w_data_i,
  output logic         rq1_waitrequest_n_o,
  output ddr_data_t    rq1_r_data_o,
  output logic         rq1_r_valid_o,

  output ddr_address_t ddr_address_o,
  output logic         ddr_r_en_o,
  output logic         ddr_w_en_o,
  output ddr_data_t    ddr_w_data_o,
  input  logic         ddr_waitrequest_n_i,
  input  ddr_data_t    ddr_r_data_i,
  input  logic         ddr_r_valid_i,

  output logic         err_o
);

  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = PtrW + 1;

  logic            tag_mem_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            last_grant_q, last_grant_d;
  logic            err_q, err_d;

  logic req0, req1, rd0, rd1, elig0, elig1;
  logic full, empty;
  logic gnt_valid, gnt_port;
  logic accept, push, pop, head_port;

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

  // A port with both enables high is a write; the read enable is ignored.
  assign req0  = rq0_r_en_i | rq0_w_en_i;
  assign req1  = rq1_r_en_i | rq1_w_en_i;
  assign rd0   = rq0_r_en_i & ~rq0_w_en_i;
  assign rd1   = rq1_r_en_i & ~rq1_w_en_i;
  assign elig0 = req0 & (rq0_w_en_i | ~full);
  assign elig1 = req1 & (rq1_w_en_i | ~full);

  assign gnt_valid = elig0 | elig1;
  assign gnt_port  = (elig0 & elig1) ? ~last_grant_q : elig1;

  assign ddr_address_o = gnt_port ? rq1_address_i : rq0_address_i;
  assign ddr_w_data_o  = gnt_port ? rq1_w_data_i  : rq0_w_data_i;
  assign ddr_w_en_o    = gnt_valid & (gnt_port ? rq1_w_en_i : rq0_w_en_i);
  assign ddr_r_en_o    = gnt_valid & (gnt_port ? rd1 : rd0);

  // An idle port sees the DDR ready only when nobody else holds the grant.
  assign rq0_waitrequest_n_o = ddr_waitrequest_n_i &
                               ((gnt_valid & ~gnt_port) | (~req0 & ~gnt_valid));
  assign rq1_waitrequest_n_o = ddr_waitrequest_n_i &
                               ((gnt_valid & gnt_port) | (~req1 & ~gnt_valid));

  assign accept    = gnt_valid & ddr_waitrequest_n_i;
  assign push      = accept & ddr_r_en_o;
  assign pop       = ddr_r_valid_i & ~empty;
  assign head_port = tag_mem_q[rd_ptr_q];

  assign rq0_r_valid_o = pop & ~head_port;
  assign rq1_r_valid_o = pop & head_port;
  assign rq0_r_data_o  = ddr_r_data_i;
  assign rq1_r_data_o  = ddr_r_data_i;
  assign err_o         = err_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CntW'(push) - CntW'(pop);
    last_grant_d = last_grant_q;
    err_d        = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (accept) last_grant_d = gnt_port;
    if ((ddr_r_valid_i & empty) | (rq0_r_en_i & rq0_w_en_i) | (rq1_r_en_i & rq1_w_en_i))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) tag_mem_q[wr_ptr_q] <= gnt_port;
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: round-robin, FIFO routing, full, stall, errors, reset.
module tb_ddr_port_arbiter;
  import config_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  ddr_address_t rq0_address_i, rq1_address_i, ddr_address_o;
  logic         rq0_r_en_i, rq0_w_en_i, rq1_r_en_i, rq1_w_en_i;
  ddr_data_t    rq0_w_data_i, rq1_w_data_i, rq0_r_data_o, rq1_r_data_o;
  logic         rq0_waitrequest_n_o, rq1_waitrequest_n_o;
  logic         rq0_r_valid_o, rq1_r_valid_o;
  logic         ddr_r_en_o, ddr_w_en_o;
  ddr_data_t    ddr_w_data_o, ddr_r_data_i;
  logic         ddr_waitrequest_n_i, ddr_r_valid_i;
  logic         err_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  ddr_port_arbiter #(.MaxOutstanding(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rq0_address_i(rq0_address_i), .rq0_r_en_i(rq0_r_en_i), .rq0_w_en_i(rq0_w_en_i),
    .rq0_w_data_i(rq0_w_data_i), .rq0_waitrequest_n_o(rq0_waitrequest_n_o),
    .rq0_r_data_o(rq0_r_data_o), .rq0_r_valid_o(rq0_r_valid_o),
    .rq1_address_i(rq1_address_i), .rq1_r_en_i(rq1_r_en_i), .rq1_w_en_i(rq1_w_en_i),
    .rq1_w_data_i(rq1_w_data_i), .rq1_waitrequest_n_o(rq1_waitrequest_n_o),
    .rq1_r_data_o(rq1_r_data_o), .rq1_r_valid_o(rq1_r_valid_o),
    .ddr_address_o(ddr_address_o), .ddr_r_en_o(ddr_r_en_o), .ddr_w_en_o(ddr_w_en_o),
    .ddr_w_data_o(ddr_w_data_o), .ddr_waitrequest_n_i(ddr_waitrequest_n_i),
    .ddr_r_data_i(ddr_r_data_i), .ddr_r_valid_i(ddr_r_valid_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    rq0_r_en_i = 0; rq0_w_en_i = 0; rq1_r_en_i = 0; rq1_w_en_i = 0;
    ddr_r_valid_i = 0;
  endtask

  initial begin
    rst_i = 1; idle();
    rq0_address_i = 32'h10; rq1_address_i = 32'h20;
    rq0_w_data_i = 32'hAAAA_0000; rq1_w_data_i = 32'hBBBB_1111;
    ddr_r_data_i = '0; ddr_waitrequest_n_i = 1;

    // Reset
    tick(); tick();
    chk("rst_rvalid0", rq0_r_valid_o, 0);
    chk("rst_rvalid1", rq1_r_valid_o, 0);
    rst_i = 0; #1;
    chk("rst_err", err_o, 0);
    chk("rst_count", dut.count_q, 0);
    chk("rst_last_grant", dut.last_grant_q, 1);
    chk("idle_wrn0", rq0_waitrequest_n_o, 1);

    // Both ports read continuously: grants alternate 0,1,0,1
    rq0_r_en_i = 1; rq1_r_en_i = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_addr", ddr_address_o, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_ren", ddr_r_en_o, 1);
      chk("rr_wrn0", rq0_waitrequest_n_o, (i % 2 == 0) ? 1 : 0);
      chk("rr_wrn1", rq1_waitrequest_n_o, (i % 2 == 0) ? 0 : 1);
      tick();
    end
    idle(); #1;
    chk("rr_count", dut.count_q, 4);

    // Returns route in issue order 0,1,0,1
    ddr_r_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      ddr_r_data_i = 32'hD000_0000 + i; #1;
      chk("ret_rv0", rq0_r_valid_o, (i % 2 == 0) ? 1 : 0);
      chk("ret_rv1", rq1_r_valid_o, (i % 2 == 0) ? 0 : 1);
      chk("ret_data", (i % 2 == 0) ? rq0_r_data_o : rq1_r_data_o, 32'hD000_0000 + i);
      tick();
    end
    idle(); #1;
    chk("ret_count", dut.count_q, 0);
    chk("ret_err", err_o, 0);

    // DDR stall for 3 cycles with a port 0 write pending
    rq0_w_en_i = 1; ddr_waitrequest_n_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wen", ddr_w_en_o, 1);
      chk("stall_wrn0", rq0_waitrequest_n_o, 0);
      tick();
      chk("stall_last", dut.last_grant_q, 1);
    end
    ddr_waitrequest_n_i = 1; #1;
    chk("stall_accept_wrn0", rq0_waitrequest_n_o, 1);
    chk("stall_wdata", ddr_w_data_o, 32'hAAAA_0000);
    tick();
    chk("stall_last_upd", dut.last_grant_q, 0);
    idle();

    // Fill FIFO with 8 port-0 reads, returns withheld
    rq0_r_en_i = 1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("full_count", dut.count_q, 8);
    chk("full_wrn0", rq0_waitrequest_n_o, 0);
    chk("full_ren", ddr_r_en_o, 0);
    rq1_w_en_i = 1; rq1_address_i = 32'h40; #1;
    chk("full_wr_addr", ddr_address_o, 32'h40);
    chk("full_wr_wen", ddr_w_en_o, 1);
    chk("full_wrn1", rq1_waitrequest_n_o, 1);
    chk("full_wrn0_b", rq0_waitrequest_n_o, 0);
    tick();
    rq1_w_en_i = 0;
    // Full with a return in the same cycle still blocks the read
    ddr_r_valid_i = 1; #1;
    chk("full_ret_wrn0", rq0_waitrequest_n_o, 0);
    chk("full_ret_rv0", rq0_r_valid_o, 1);
    tick();
    idle(); #1;
    chk("full_ret_count", dut.count_q, 7);

    // Port 1 read accepted while a port 0 return arrives
    rq1_r_en_i = 1; ddr_r_valid_i = 1; #1;
    chk("sim_wrn1", rq1_waitrequest_n_o, 1);
    chk("sim_rv0", rq0_r_valid_o, 1);
    chk("sim_rv1", rq1_r_valid_o, 0);
    tick();
    rq1_r_en_i = 0; #1;
    chk("sim_count", dut.count_q, 7);
    for (int i = 0; i < 6; i++) begin
      #1; chk("drain_rv0", rq0_r_valid_o, 1);
      tick();
    end
    #1;
    chk("drain_last_rv1", rq1_r_valid_o, 1);
    chk("drain_last_rv0", rq0_r_valid_o, 0);
    tick();

    // Return with empty FIFO
    #1;
    chk("empty_count", dut.count_q, 0);
    chk("empty_rv0", rq0_r_valid_o, 0);
    chk("empty_rv1", rq1_r_valid_o, 0);
    tick();
    idle(); #1;
    chk("empty_err", err_o, 1);
    tick(); tick();
    chk("err_sticky", err_o, 1);

    // Reset with 3 reads outstanding
    rq1_r_en_i = 1;
    tick(); tick(); tick();
    idle(); #1;
    chk("pre_rst_count", dut.count_q, 3);
    rst_i = 1; tick(); rst_i = 0; #1;
    chk("post_rst_count", dut.count_q, 0);
    chk("post_rst_err", err_o, 0);
    rq0_w_en_i = 1; rq1_w_en_i = 1;
    rq0_address_i = 32'h100; rq1_address_i = 32'h200; #1;
    chk("post_rst_tie", ddr_address_o, 32'h100);
    chk("post_rst_tie_wrn1", rq1_waitrequest_n_o, 0);
    tick();
    idle(); ddr_r_valid_i = 1; #1;
    chk("stale_rv0", rq0_r_valid_o, 0);
    chk("stale_rv1", rq1_r_valid_o, 0);
    tick();
    idle(); #1;
    chk("stale_err", err_o, 1);

    // Both enables on one port: treated as write, flagged
    rst_i = 1; tick(); rst_i = 0;
    rq0_r_en_i = 1; rq0_w_en_i = 1; #1;
    chk("both_wen", ddr_w_en_o, 1);
    chk("both_ren", ddr_r_en_o, 0);
    tick();
    idle(); #1;
    chk("both_err", err_o, 1);
    chk("both_count", dut.count_q, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 8, SHALL set the maximum number of accepted-but-unreturned DDR reads; legal range 2..64, power of two.
REQ-002 Package config_pkg::* SHALL supply ddr_address_t and ddr_data_t.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 rq0_* is port 0 (vector load/store unit); rq1_* is port 1 (matrix fetch unit). Both ports have identical signal sets, per port p:
REQ-006 rqp_address_i  in  ddr_address_t  request word address.
REQ-007 rqp_r_en_i  in  1  read request.
REQ-008 rqp_w_en_i  in  1  write request.
REQ-009 rqp_w_data_i  in  ddr_data_t  write data.
REQ-010 rqp_waitrequest_n_o  out  1  high = request on port p accepted this cycle if asserted.
REQ-011 rqp_r_data_o  out  ddr_data_t  read return data.
REQ-012 rqp_r_valid_o  out  1  read return strobe.
REQ-013 ddr_address_o  out  ddr_address_t  DDR command address.
REQ-014 ddr_r_en_o / ddr_w_en_o  out  1 each  DDR read / write command.
REQ-015 ddr_w_data_o  out  ddr_data_t  DDR write data.
REQ-016 ddr_waitrequest_n_i  in  1  DDR accepts command this cycle when high.
REQ-017 ddr_r_data_i  in  ddr_data_t; ddr_r_valid_i  in  1  in-order read returns.
REQ-018 err_o  out  1  sticky protocol-error flag.

Function
REQ-019 Port p SHALL be requesting when rqp_r_en_i or rqp_w_en_i is high; a read is eligible only if the outstanding count is below MaxOutstanding.
REQ-020 Grant SHALL be combinational: one eligible port -> that port; both eligible -> the port not recorded in last_grant_q (round-robin).
REQ-021 Granted port's address/enables/write data SHALL drive ddr_* combinationally in the same cycle; with no grant, ddr_r_en_o=ddr_w_en_o=0 and address/data are don't-care.
REQ-022 rqp_waitrequest_n_o SHALL equal ddr_waitrequest_n_i when port p is granted or when port p is idle and no grant exists; otherwise 0.
REQ-023 A transfer is accepted when the granted port's enable is high and ddr_waitrequest_n_i is high; on accept, last_grant_q SHALL update to the granted port at the next edge.
REQ-024 No transfer accepted -> last_grant_q holds; a stalled granted request keeps its grant next cycle unless the other port has priority and is eligible.
REQ-025 Accepted read SHALL push the source port ID into an in-order tag FIFO of depth MaxOutstanding; outstanding count +1.
REQ-026 ddr_r_valid_i SHALL pop the FIFO head, pulse rqX_r_valid_o for the head port in the same cycle with rqX_r_data_o=ddr_r_data_i; the other port's r_valid stays 0; count -1.
REQ-027 Simultaneous accepted read and return SHALL leave count unchanged and keep FIFO order correct.
REQ-028 Full FIFO (count == MaxOutstanding) SHALL block reads from both ports (waitrequest_n 0 for reading ports) even if a return arrives that cycle; writes remain eligible.
REQ-029 ddr_r_valid_i with empty FIFO SHALL drop the data, assert no rq r_valid, and set err_o.
REQ-030 A port asserting r_en and w_en together SHALL be treated as a write only and set err_o.
REQ-031 err_o SHALL remain set until reset.
REQ-032 Pointers SHALL wrap modulo MaxOutstanding; count width SHALL be $clog2(MaxOutstanding)+1.

Reset
REQ-033 While rst_i is high at an edge: FIFO empty, count 0, last_grant_q = port 1 (port 0 wins first tie), err_o 0.
REQ-034 Reads outstanding at reset SHALL be forgotten; later returns before new reads SHALL set err_o per REQ-029.
REQ-035 During and after reset all rq r_valid outputs SHALL be 0 until a tagged return arrives.

Verification
REQ-036 Both ports read continuously, waitrequest_n=1 -> grants alternate 0,1,0,1; returns route by issue order.
REQ-037 MaxOutstanding=8, returns withheld, port 0 issues 8 reads -> 9th read stalled (rq0_waitrequest_n_o=0); port 1 write at 0x40 still accepted.
REQ-038 Same cycle: port 1 read accepted and return for port 0 tag -> rq0_r_valid_o=1, count unchanged.
REQ-039 ddr_waitrequest_n_i=0 for 3 cycles with port 0 write pending -> no accept, last_grant_q unchanged; accepted in cycle 4.
REQ-040 ddr_r_valid_i=1 with empty FIFO -> no rq r_valid, err_o=1 held until rst_i.
REQ-041 rst_i asserted with 3 reads outstanding -> count 0, err_o 0; first post-reset tie granted to port 0.
